// File: rtl/axi_burst_reader.sv
// axi_burst_reader: AXI4 read master for the cache/LSU request port.
// One AR per request (single narrow read or INCR burst of up to MAX_BEATS
// full-width beats). Beats are gathered into a line buffer and a one-cycle
// response pulse returns the narrow data, the whole line and the merged RRESP.
// Optional watchdog: define AXI_BURST_READER_TIMEOUT_EN to add the timeout
// counter and the sticky timeout_o output.
module axi_burst_reader #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned ID_W           = 4,
    parameter int unsigned MAX_BEATS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    // request / response port
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ID_W-1:0]             req_id,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [7:0]                  req_len,
    input  logic [2:0]                  req_size,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [MAX_BEATS*DATA_W-1:0] rsp_line,
    output logic [1:0]                  rsp_resp,
    output logic [4:0]                  rsp_beats,
    // AXI AR channel
    output logic                        arvalid,
    input  logic                        arready,
    output logic [ID_W-1:0]             arid,
    output logic [ADDR_W-1:0]           araddr,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic [2:0]                  arprot,
    output logic [3:0]                  arcache,
    output logic                        arlock,
    output logic [3:0]                  arqos,
    output logic [3:0]                  arregion,
    // AXI R channel
    input  logic                        rvalid,
    output logic                        rready,
    input  logic [ID_W-1:0]             rid,
    input  logic [DATA_W-1:0]           rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast
`ifdef AXI_BURST_READER_TIMEOUT_EN
    ,
    output logic                        timeout_o
`endif
);

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_id;
    logic [OFF_W-1:0]  r_off;
    logic [7:0]        r_len;
    logic [2:0]        r_size;

    logic [2:0]        w_eff_size;
    int unsigned       w_bits;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_mask;

`ifdef AXI_BURST_READER_TIMEOUT_EN
    logic [15:0]       r_to_cnt;
`endif

    function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign req_ready = (r_state == IDLE);
    assign arprot    = '0;
    assign arcache   = '0;
    assign arlock    = 1'b0;
    assign arqos     = '0;
    assign arregion  = '0;

    // Narrow extract from the stored beat 0: shift by byte offset, mask to the (clamped) size
    always_comb begin
        w_eff_size = 3'(OFF_W);
        if (r_len == 8'd0 && r_size < 3'(OFF_W)) begin
            w_eff_size = r_size;
        end
        w_bits    = 32'd8 << w_eff_size;
        w_shifted = rsp_line[DATA_W-1:0] >> {r_off, 3'b000};
        w_mask    = '1;
        if (w_eff_size < 3'(OFF_W)) begin
            w_mask = (DATA_W'(1) << w_bits) - DATA_W'(1);
        end
        rsp_data = w_shifted & w_mask;
    end

    // Control FSM, AR/R handshakes, line buffer and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_off     <= '0;
            r_len     <= '0;
            r_size    <= '0;
            arvalid   <= 1'b0;
            arid      <= '0;
            araddr    <= '0;
            arlen     <= '0;
            arsize    <= '0;
            arburst   <= '0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_line  <= '0;
            rsp_resp  <= '0;
            rsp_beats <= '0;
`ifdef AXI_BURST_READER_TIMEOUT_EN
            r_to_cnt  <= '0;
            timeout_o <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_id      <= req_id;
                        r_off     <= req_addr[OFF_W-1:0];
                        r_len     <= req_len;
                        r_size    <= req_size;
                        arid      <= req_id;
                        araddr    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        arlen     <= req_len;
                        arsize    <= (req_len == 8'd0) ? req_size : 3'(OFF_W);
                        arburst   <= 2'b01;
                        arvalid   <= 1'b1;
                        rsp_resp  <= '0;
                        rsp_beats <= '0;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    // rready is always high here, so rvalid alone is a handshake
                    if (rvalid) begin
                        if (rid != r_id) begin
                            // foreign beat: consumed, never stored, rlast ignored
                            rsp_resp <= rmax(rsp_resp, 2'b10);
                        end else if ({3'b000, rsp_beats} > r_len) begin
                            rsp_resp <= rmax(rsp_resp, 2'b10);
                            if (rlast) begin
                                rready    <= 1'b0;
                                rsp_valid <= 1'b1;
                                r_state   <= RESP;
                            end
                        end else begin
                            for (int unsigned k = 0; k < MAX_BEATS; k++) begin
                                if (rsp_beats == 5'(k)) begin
                                    rsp_line[k*DATA_W +: DATA_W] <= rdata;
                                end
                            end
                            rsp_beats <= rsp_beats + 5'd1;
                            if (rlast && ({3'b000, rsp_beats} < r_len)) begin
                                rsp_resp <= rmax(rmax(rsp_resp, rresp), 2'b10);
                            end else begin
                                rsp_resp <= rmax(rsp_resp, rresp);
                            end
                            if (rlast) begin
                                rready    <= 1'b0;
                                rsp_valid <= 1'b1;
                                r_state   <= RESP;
                            end
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
`ifdef AXI_BURST_READER_TIMEOUT_EN
            // Watchdog: runs only while waiting in ADDR/DATA; any handshake or entry restarts it
            if ((r_state == ADDR && !arready) || (r_state == DATA && !rvalid)) begin
                if (32'(r_to_cnt) + 32'd1 >= TIMEOUT_CYCLES) begin
                    arvalid   <= 1'b0;
                    rready    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_resp  <= 2'b11;
                    timeout_o <= 1'b1;
                    r_to_cnt  <= '0;
                    r_state   <= RESP;
                end else begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                end
            end else begin
                r_to_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Directed bench for axi_burst_reader with a response scoreboard.
module tb_axi_burst_reader;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned MB = 8;
    localparam int unsigned LW = MB * DW;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic [IW-1:0]  req_id;
    logic [AW-1:0]  req_addr;
    logic [7:0]     req_len;
    logic [2:0]     req_size;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_data;
    logic [LW-1:0]  rsp_line;
    logic [1:0]     rsp_resp;
    logic [4:0]     rsp_beats;
    logic           arvalid;
    logic           arready;
    logic [IW-1:0]  arid;
    logic [AW-1:0]  araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic [2:0]     arprot;
    logic [3:0]     arcache;
    logic           arlock;
    logic [3:0]     arqos;
    logic [3:0]     arregion;
    logic           rvalid;
    logic           rready;
    logic [IW-1:0]  rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
`ifdef AXI_BURST_READER_TIMEOUT_EN
    logic           timeout_o;
`endif

    always #5 clk = ~clk;

    axi_burst_reader #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .ID_W(IW),
        .MAX_BEATS(MB),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_line(rsp_line),
        .rsp_resp(rsp_resp), .rsp_beats(rsp_beats),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arprot(arprot),
        .arcache(arcache), .arlock(arlock), .arqos(arqos), .arregion(arregion),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast)
`ifdef AXI_BURST_READER_TIMEOUT_EN
        , .timeout_o(timeout_o)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [LW-1:0] line;
        logic [1:0]    resp;
        logic [4:0]    beats;
    } exp_t;

    exp_t          sb[$];
    exp_t          e_mon;
    logic [DW-1:0] m_line [MB];
    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack_line();
        logic [LW-1:0] v;
        for (int k = 0; k < MB; k++) v[k*DW +: DW] = m_line[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic [1:0] r, input logic [4:0] b);
        exp_t e;
        e.data  = d;
        e.line  = pack_line();
        e.resp  = r;
        e.beats = b;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [IW-1:0] id, input logic [AW-1:0] a,
                         input logic [7:0] len, input logic [2:0] sz);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_id    = id;
        req_addr  = a;
        req_len   = len;
        req_size  = sz;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ar_accept();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("ar_done", {arvalid, rready}, 2'b01);
    endtask

    task automatic send_beat(input logic [IW-1:0] id, input logic [DW-1:0] d,
                             input logic [1:0] r, input logic last);
        int w;
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
        rresp  = r;
        rlast  = last;
        w = 0;
        while (!rready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) chk("rready_wait_expired", 0, 1);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic finish_rsp();
        chk("rsp_pulse", {rsp_valid, req_ready, rready}, 3'b100);
        tick();
        chk("rsp_done", {rsp_valid, req_ready}, 2'b01);
    endtask

    // Scoreboard check on every response pulse
    always @(posedge clk) begin
        #1;
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e_mon = sb.pop_front();
                chk("rsp_data", rsp_data, e_mon.data);
                chk("rsp_line", rsp_line, e_mon.line);
                chk("rsp_resp", rsp_resp, e_mon.resp);
                chk("rsp_beats", rsp_beats, e_mon.beats);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_id = '0; req_addr = '0; req_len = '0; req_size = '0;
        arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
        for (int k = 0; k < MB; k++) m_line[k] = '0;
        tick(); tick(); tick();

        // reset state
        chk("rst_ctrl", {req_ready, arvalid, rready, rsp_valid}, 4'b1000);
        chk("rst_ar", {arid, araddr, arlen, arsize, arburst}, 0);
        chk("rst_const", {arprot, arcache, arlock, arqos, arregion}, 0);
        chk("rst_rsp", {rsp_data, rsp_resp, rsp_beats}, 0);
        chk("rst_line", rsp_line, 0);
        reset = 1'b0;
        tick();

        // single 4-byte read at offset 4
        issue(4'd1, 64'h8000_0004, 8'd0, 3'd2);
        chk("ar_single", {arvalid, arid, araddr, arlen, arsize, arburst},
            {1'b1, 4'd1, 64'h8000_0000, 8'd0, 3'd2, 2'b01});
        ar_accept();
        m_line[0] = 64'h1122_3344_5566_7788;
        push_exp(64'h1122_3344, 2'b00, 5'd1);
        send_beat(4'd1, 64'h1122_3344_5566_7788, 2'b00, 1'b1);
        finish_rsp();

        // four-beat burst
        issue(4'd2, 64'h8000_0018, 8'd3, 3'd0);
        chk("ar_burst", {arvalid, arid, araddr, arlen, arsize, arburst},
            {1'b1, 4'd2, 64'h8000_0018, 8'd3, 3'd3, 2'b01});
        ar_accept();
        for (int k = 0; k < 4; k++) begin
            m_line[k] = 64'hA0 + 64'(k);
            if (k == 3) push_exp(64'hA0, 2'b00, 5'd4);
            send_beat(4'd2, 64'hA0 + 64'(k), 2'b00, k == 3);
        end
        finish_rsp();

        // AR stall of 5 cycles, request inputs wiggled meanwhile
        issue(4'd3, 64'h1000, 8'd0, 3'd3);
        req_valid = 1'b1; req_id = 4'd9; req_addr = 64'hDEAD_BEEF_0000_0040; req_len = 8'd2; req_size = 3'd1;
        for (int i = 0; i < 6; i++) begin
            chk("ar_stall", {arvalid, arid, araddr, arlen, arsize, arburst, req_ready},
                {1'b1, 4'd3, 64'h1000, 8'd0, 3'd3, 2'b01, 1'b0});
            if (i < 5) tick();
        end
        ar_accept();
        req_valid = 1'b0;
        m_line[0] = 64'h0123_4567_89AB_CDEF;
        push_exp(64'h0123_4567_89AB_CDEF, 2'b00, 5'd1);
        send_beat(4'd3, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1);
        finish_rsp();

        // SLVERR on beat 2 plus a foreign-ID beat
        issue(4'd4, 64'h2000, 8'd3, 3'd3);
        ar_accept();
        m_line[0] = 64'hB0; m_line[1] = 64'hB1; m_line[2] = 64'hB2; m_line[3] = 64'hB3;
        send_beat(4'd4, 64'hB0, 2'b00, 1'b0);
        send_beat(4'd5, 64'hBAD, 2'b00, 1'b0);
        send_beat(4'd4, 64'hB1, 2'b00, 1'b0);
        send_beat(4'd4, 64'hB2, 2'b10, 1'b0);
        push_exp(64'hB0, 2'b10, 5'd4);
        send_beat(4'd4, 64'hB3, 2'b00, 1'b1);
        finish_rsp();

        // early rlast after 2 of 4 beats: words 2..3 keep old contents
        issue(4'd7, 64'h4000, 8'd3, 3'd3);
        ar_accept();
        m_line[0] = 64'hC0; m_line[1] = 64'hC1;
        send_beat(4'd7, 64'hC0, 2'b00, 1'b0);
        push_exp(64'hC0, 2'b10, 5'd2);
        send_beat(4'd7, 64'hC1, 2'b00, 1'b1);
        finish_rsp();

        // reset in the middle of the data phase
        issue(4'd6, 64'h3000, 8'd3, 3'd3);
        ar_accept();
        send_beat(4'd6, 64'hD0, 2'b00, 1'b0);
        send_beat(4'd6, 64'hD1, 2'b00, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < MB; k++) m_line[k] = '0;
        chk("midrst_ctrl", {req_ready, rready, rsp_valid, arvalid}, 4'b1000);
        chk("midrst_rsp", {rsp_resp, rsp_beats, araddr}, 0);
        chk("midrst_line", rsp_line, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_pulse", rsp_valid, 0);
        end

        // 2-byte read at offset 6
        issue(4'd8, 64'h5006, 8'd0, 3'd1);
        chk("ar_narrow", {araddr, arsize}, {64'h5000, 3'd1});
        ar_accept();
        m_line[0] = 64'hAABB_CCDD_EEFF_1122;
        push_exp(64'hAABB, 2'b00, 5'd1);
        send_beat(4'd8, 64'hAABB_CCDD_EEFF_1122, 2'b00, 1'b1);
        finish_rsp();

`ifdef AXI_BURST_READER_TIMEOUT_EN
        // watchdog expiry with no R beats
        begin
            int cyc;
            issue(4'd9, 64'h0, 8'd0, 3'd3);
            ar_accept();
            push_exp(m_line[0], 2'b11, 5'd0);
            cyc = 0;
            while (rsp_valid !== 1'b1 && cyc < 100) begin
                tick();
                cyc++;
            end
            chk("timeout_latency", cyc, 16);
            chk("timeout_flag", {timeout_o, rready, arvalid}, 3'b100);
            finish_rsp();
        end
`endif

        tick(); tick();
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_burst_reader.md
Name: axi_burst_reader

Overview:
- Parametrised AXI4 read master that replaces the single-beat read engine.
- Issues one AR per CPU/cache request, either a single narrow read or an INCR burst of up to MAX_BEATS full-width beats.
- Collects the returned beats into a line buffer and returns a one-cycle response. The response carries the right-justified narrow data, the full line, and the merged response code.
- Sits between the cache/LSU request port and the AXI crossbar read channels.

Parameters:
- ADDR_W, 64, address width (AR and request).
- DATA_W, 64, AXI data width; power of two, 32..256.
- ID_W, 4, AXI ID width.
- MAX_BEATS, 8, line buffer depth in beats; power of two, 1..16.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_id  in  ID_W  transaction ID
- req_addr  in  ADDR_W  byte address
- req_len  in  8  beats minus one; must be < MAX_BEATS
- req_size  in  3  log2 bytes for a single-beat read; ignored when req_len>0
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  DATA_W  beat 0, shifted right by the address offset, masked to req_size, zero-extended
- rsp_line  out  MAX_BEATS*DATA_W  beat k at bits [k*DATA_W +: DATA_W]
- rsp_resp  out  2  merged response code
- rsp_beats  out  5  number of beats stored
- arvalid/arready/arid/araddr/arlen/arsize/arburst  AXI AR channel (out/in/out...); arburst width 2
- arprot=0, arcache=0, arlock=0, arqos=0, arregion=0  out, constant
- rvalid/rready/rid/rdata/rresp/rlast  AXI R channel

Behaviour:
- States: IDLE, ADDR, DATA, RESP.
- Reset values:
  - state=IDLE
  - arvalid=0, rready=0, rsp_valid=0
  - all AR fields, rsp_data, rsp_line, rsp_resp and rsp_beats = 0
- req_ready = (state==IDLE).
- Request accept (req_valid&req_ready):
  - Latch id, addr, len and size into registers.
  - Go to ADDR; arvalid is registered and goes high the next cycle.
- ADDR:
  - arvalid=1 and all AR fields are held stable until arready; independent of request inputs.
  - araddr = req_addr with the low log2(DATA_W/8) bits cleared.
  - arlen = len; arburst = INCR (2'b01).
  - arsize = size if len==0, else log2(DATA_W/8).
  - On handshake go to DATA; arvalid drops the same edge.
- DATA:
  - rready=1; beat_cnt starts at 0.
  - A beat with rid==id is written to line[beat_cnt]; beat_cnt increments; rsp_resp = max(rsp_resp, rresp).
  - Accumulator clears to 0 at request accept.
  - A beat with rid!=id is consumed and discarded; rsp_resp forced to 2'b10 (sticky).
  - A beat arriving when beat_cnt>len is discarded; rsp_resp forced to 2'b10.
  - Exit on an accepted beat with rlast=1.
  - rlast before beat_cnt==len: exit with rsp_resp forced to 2'b10; unfilled line words retain their old contents.
- RESP:
  - rsp_valid=1 for exactly one cycle; no backpressure.
  - rsp_data is computed from the stored beat 0, not live rdata.
  - Next state is IDLE.
- Latency:
  - Request accepted at cycle 0; arvalid at cycle 1.
  - Last R handshake at cycle N gives rsp_valid at N+1 and req_ready at N+2.
- Narrow extract: shift = addr[log2(DATA_W/8)-1:0]*8; mask = (2^(8<<size))-1. Sizes larger than DATA_W are clamped to DATA_W.
- Reset in any state: the block returns to IDLE on the next edge, all outputs go to their reset values, and the outstanding AXI transaction is abandoned.
- Simultaneous rvalid and a state exit: the handshake is decided by the current state only.

Optional Feature:
- Macro: AXI_BURST_READER_TIMEOUT_EN.
- Enabled:
  - A 16-bit counter clears on entry to ADDR/DATA and on every AR/R handshake, and increments otherwise while in ADDR/DATA.
  - When the counter reaches TIMEOUT_CYCLES, the block goes to RESP with rsp_resp=2'b11; arvalid/rready drop.
  - A sticky output timeout_o (1 bit, reset 0) sets at that point and clears only on reset.
- Disabled: no counter and no timeout_o port; the block waits indefinitely.

Test Plan:
- Single 4-byte read, addr=0x8000_0004, len=0, size=2, rdata=0x1122334455667788 OKAY rlast → araddr=0x8000_0000, arsize=2, rsp_data=0x11223344, rsp_resp=0, rsp_valid one cycle.
- Burst len=3, addr=0x8000_0018, beats D0..D3 = 0xA0..0xA3 → araddr=0x8000_0018, arlen=3, arsize=3, arburst=1, rsp_line words 0..3 = 0xA0..0xA3, rsp_beats=4.
- arready held low 5 cycles → AR fields stable and arvalid high for all 6 cycles; request inputs changed during the stall have no effect.
- Burst len=3 with beat 2 rresp=SLVERR, plus one beat with a wrong rid → rsp_resp=2'b10, wrong-rid beat absent from rsp_line, rsp_beats=4.
- reset asserted mid-DATA after 2 beats → next cycle state=IDLE, req_ready=1, rready=0, rsp_valid never pulses.
- TIMEOUT_EN with TIMEOUT_CYCLES=16, rvalid never asserted → rsp_valid exactly 16 cycles after the AR handshake, rsp_resp=2'b11, timeout_o=1.
